// File: rtl/router_pkg.sv
// Shared constants and helpers for the router packet path.
package router_pkg;

    localparam int PKT_W      = 55;
    localparam int FIFO_DEPTH = 4;

    // Pointer width: at least one bit even for tiny depths
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/router_fifo_ptr.sv
// Wrap-at-DEPTH index pointer with increment enable and sync clear.
module router_fifo_ptr
    import router_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          inc,
    output logic [clog2_min1(DEPTH)-1:0]  ptr
);

    localparam int PW = clog2_min1(DEPTH);

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr == PW'(DEPTH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_pkt_fifo.sv
// First-word-fall-through packet FIFO for a router input port.
// Optional sticky overflow/underflow flags with ROUTER_FIFO_ERR_EN.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = PKT_W,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
`ifdef ROUTER_FIFO_ERR_EN
    ,
    output logic                       err_ovf,
    output logic                       err_udf
`endif
);

    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic              clr;

    assign clr       = rst | flush;
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + 1'b1;
        end else if (!push && pop) begin
            count <= count - 1'b1;
        end
    end

    router_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .clr (clr),
        .inc (push),
        .ptr (wr_ptr)
    );

    router_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .clr (clr),
        .inc (pop),
        .ptr (rd_ptr)
    );

`ifdef ROUTER_FIFO_ERR_EN
    // Sticky until rst; flush deliberately leaves them set
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (in_valid && full) begin
                err_ovf <= 1'b1;
            end
            if (out_ready && empty) begin
                err_udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo (DEPTH=4, DATA_W=55).
module tb_router_pkt_fifo;

    localparam int DW = 55;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
`ifdef ROUTER_FIFO_ERR_EN
    logic          err_ovf;
    logic          err_udf;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    router_pkt_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef ROUTER_FIFO_ERR_EN
        ,
        .err_ovf   (err_ovf),
        .err_udf   (err_udf)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " empty"}, 64'(empty), 64'd1);
        chk({tag, " full"}, 64'(full), 64'd0);
        chk({tag, " count"}, 64'(count), 64'd0);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " out_data"}, 64'(out_data), 64'd0);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic push1(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: every accepted pop must match the scoreboard head
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1 && !rst && !flush) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_unexpected: got %0h expected none",
                         out_data);
            end else begin
                chk("pop_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();
        chk_idle("idle");
`ifdef ROUTER_FIFO_ERR_EN
        chk("rst err_ovf", 64'(err_ovf), 64'd0);
        chk("rst err_udf", 64'(err_udf), 64'd0);
`endif

        for (int i = 1; i <= 4; i++) begin
            push1(DW'(i));
        end
        chk("fill full", 64'(full), 64'd1);
        chk("fill count", 64'(count), 64'd4);
        chk("fill in_ready", 64'(in_ready), 64'd0);

        in_valid = 1'b1;
        in_data  = DW'(5);
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        chk("ovf count", 64'(count), 64'd4);
        chk("ovf head_stable", 64'(out_data), 64'd1);
`ifdef ROUTER_FIFO_ERR_EN
        chk("ovf err_ovf", 64'(err_ovf), 64'd1);
`endif

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        out_ready = 1'b0;
        chk("drain empty", 64'(empty), 64'd1);
        chk("drain count", 64'(count), 64'd0);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("udf count", 64'(count), 64'd0);
        chk("udf empty", 64'(empty), 64'd1);
`ifdef ROUTER_FIFO_ERR_EN
        chk("udf err_udf", 64'(err_udf), 64'd1);
        chk("udf err_ovf_held", 64'(err_ovf), 64'd1);
`endif

        push1(DW'('h10));
        push1(DW'('h11));
        chk("pre_wrap count", 64'(count), 64'd2);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = DW'('h12 + k);
            exp_q.push_back(DW'('h12 + k));
            tick();
            chk("wrap count", 64'(count), 64'd2);
        end
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        chk("wrap drained", 64'(count), 64'd0);

        push1(DW'('h20));
        push1(DW'('h21));
        push1(DW'('h22));
        chk("pre_flush count", 64'(count), 64'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'('h23);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush count", 64'(count), 64'd0);
        chk("flush empty", 64'(empty), 64'd1);
        chk("flush out_data", 64'(out_data), 64'd0);
`ifdef ROUTER_FIFO_ERR_EN
        chk("flush err_ovf_kept", 64'(err_ovf), 64'd1);
        chk("flush err_udf_kept", 64'(err_udf), 64'd1);
`endif
        push1(DW'('h24));
        chk("post_flush head", 64'(out_data), 64'h24);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        push1(DW'('hA));
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        chk("midrst count", 64'(count), 64'd0);
`ifdef ROUTER_FIFO_ERR_EN
        chk("midrst err_ovf", 64'(err_ovf), 64'd0);
`endif
        push1(DW'('hB));
        chk("midrst count1", 64'(count), 64'd1);
        chk("midrst head", 64'(out_data), 64'hB);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();

        chk("scoreboard left", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
